rojo_cmd_sched: RTL and testbench

//  Rojobot motion-command scheduler, sits between the Rojobot AHB peripheral and the bot.
//  - Queues CPU-written motor commands (BotCtrl byte + duration in bot-update ticks).
//  - Drives each command for its duration, then advances to the next.
//  - Raises the bot-update interrupt and handles the INT_ACK handshake.

---
 rtl/rojo_cmd_sched.sv | 182 ++++++++++++++++++
 tb/tb_rojo_cmd_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rojo_cmd_sched.sv
// Rojobot motion-command scheduler: queues {BotCtrl, duration} commands and plays them tick by tick.
// Latency: push to an empty queue drives bot_ctrl 2 HCLK later; bot_updt rise becomes a tick 3 edges later.
// Backpressure: none; pushes into a full queue are dropped and flagged in cmd_ovf. ROJO_WDOG_EN adds a RUN watchdog.
module rojo_cmd_sched #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DUR_W    = 8,
    parameter logic [7:0]  IDLE_CMD = 8'h00,
    parameter logic [31:0] WDOG_CYC = 32'd500000
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     cmd_wr,
    input  logic [7:0]               cmd_ctrl,
    input  logic [DUR_W-1:0]         cmd_dur,
    input  logic                     flush,
    input  logic                     bot_updt,
    input  logic                     int_ack,
    output logic [7:0]               bot_ctrl,
    output logic                     upd_int,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     fifo_full,
    output logic                     cmd_ovf,
    output logic [7:0]               miss_cnt,
    output logic                     busy,
    output logic                     wdog_fault
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FAULT} state_t;

    state_t             state_q;
    logic [7:0]         bot_ctrl_q;
    logic [DUR_W-1:0]   rem_q;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        cnt_q, cnt_d;
    logic [7:0]         mem_ctrl [DEPTH];
    logic [DUR_W-1:0]   mem_dur  [DEPTH];
    logic               sync1_q, sync2_q, sync3_q;
    logic               ack_q;
    logic               upd_q;
    logic [7:0]         miss_q;
    logic               ovf_q;
    logic               tick, ack_rise, full, empty, pop, push;

    assign tick     = sync2_q & ~sync3_q;
    assign ack_rise = int_ack & ~ack_q;
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop      = (state_q == LOAD) & ~flush;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign push     = cmd_wr & ~flush & (~full | pop);
    assign cnt_d    = flush ? '0 : cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_ctrl[wr_ptr_q] <= cmd_ctrl;
            mem_dur[wr_ptr_q]  <= cmd_dur;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            ack_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            upd_q    <= 1'b0;
            miss_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q <= bot_updt;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            ack_q   <= int_ack;
            cnt_q   <= cnt_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (tick)          upd_q <= 1'b1;
            else if (ack_rise) upd_q <= 1'b0;
            if (flush)
                miss_q <= 8'h00;
            else if (tick && upd_q && miss_q != 8'hFF)
                miss_q <= miss_q + 8'd1;
            if (flush)
                ovf_q <= 1'b0;
            else if (cmd_wr && full && !pop)
                ovf_q <= 1'b1;
        end
    end

`ifdef ROJO_WDOG_EN
    logic [31:0] wd_q;
    logic        wdog_q;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            bot_ctrl_q <= IDLE_CMD;
            rem_q      <= '0;
`ifdef ROJO_WDOG_EN
            wd_q       <= '0;
            wdog_q     <= 1'b0;
`endif
        end else if (flush) begin
            state_q    <= IDLE;
            bot_ctrl_q <= IDLE_CMD;
`ifdef ROJO_WDOG_EN
            wd_q       <= '0;
            wdog_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    bot_ctrl_q <= IDLE_CMD;
                    if (!empty) state_q <= LOAD;
                end
                LOAD: begin
                    bot_ctrl_q <= mem_ctrl[rd_ptr_q];
                    rem_q      <= (mem_dur[rd_ptr_q] == '0) ? DUR_W'(1) : mem_dur[rd_ptr_q];
                    state_q    <= RUN;
`ifdef ROJO_WDOG_EN
                    wd_q       <= '0;
`endif
                end
                RUN: begin
                    if (tick) begin
`ifdef ROJO_WDOG_EN
                        wd_q <= '0;
`endif
                        // Chaining into LOAD keeps the old command on the pins until the next one lands.
                        if (rem_q == DUR_W'(1)) begin
                            if (empty) begin
                                state_q    <= IDLE;
                                bot_ctrl_q <= IDLE_CMD;
                            end else begin
                                state_q    <= LOAD;
                            end
                        end else begin
                            rem_q <= rem_q - DUR_W'(1);
                        end
                    end
`ifdef ROJO_WDOG_EN
                    else if (wd_q == WDOG_CYC - 32'd1) begin
                        state_q    <= FAULT;
                        bot_ctrl_q <= IDLE_CMD;
                        wdog_q     <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
`endif
                end
                default: bot_ctrl_q <= IDLE_CMD;
            endcase
        end
    end

`ifdef ROJO_WDOG_EN
    assign wdog_fault = wdog_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYC;
    assign wdog_fault  = 1'b0;
`endif

    assign bot_ctrl  = bot_ctrl_q;
    assign upd_int   = upd_q;
    assign fifo_cnt  = cnt_q;
    assign fifo_full = full;
    assign cmd_ovf   = ovf_q;
    assign miss_cnt  = miss_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rojo_cmd_sched.sv
// Bench for rojo_cmd_sched: directed scenarios with literal expectations, then random traffic vs a queue model.
module tb_rojo_cmd_sched;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_ctrl = 8'h00;
    logic [7:0] cmd_dur = 8'h00;
    logic       flush = 1'b0;
    logic       bot_updt = 1'b0;
    logic       int_ack = 1'b0;
    logic [7:0] bot_ctrl;
    logic       upd_int;
    logic [3:0] fifo_cnt;
    logic       fifo_full;
    logic       cmd_ovf;
    logic [7:0] miss_cnt;
    logic       busy;
    logic       wdog_fault;

    rojo_cmd_sched dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .cmd_wr(cmd_wr), .cmd_ctrl(cmd_ctrl),
        .cmd_dur(cmd_dur), .flush(flush), .bot_updt(bot_updt), .int_ack(int_ack),
        .bot_ctrl(bot_ctrl), .upd_int(upd_int), .fifo_cnt(fifo_cnt), .fifo_full(fifo_full),
        .cmd_ovf(cmd_ovf), .miss_cnt(miss_cnt), .busy(busy), .wdog_fault(wdog_fault)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [7:0] ctrl; logic [7:0] dur; } cmd_t;
    cmd_t m_q[$];
    int   m_mode;            // 0 idle, 1 about to take head, 2 playing a command
    int   m_ctrl, m_rem, m_miss;
    bit   m_upd, m_ovf, m_ackp;
    bit   h0, h1, h2;        // bot_updt seen 1, 2, 3 edges ago

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode = 0; m_ctrl = 0; m_rem = 0; m_miss = 0;
        m_upd = 0; m_ovf = 0; m_ackp = 0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    task automatic model_step();
        bit   tick, ackr, full, pop;
        int   sz;
        cmd_t e;
        tick = h1 & ~h2;
        ackr = int_ack & ~m_ackp;
        sz   = m_q.size();
        full = (sz == 8);
        pop  = (m_mode == 1) && !flush;
        if (tick) begin
            if (m_upd && m_miss < 255) m_miss++;
            m_upd = 1;
        end else if (ackr) m_upd = 0;
        if (flush) m_miss = 0;
        if (flush) m_ovf = 0;
        else if (cmd_wr && full && !pop) m_ovf = 1;
        if (flush) begin
            m_mode = 0; m_ctrl = 0; m_q.delete();
        end else begin
            if (m_mode == 0) begin
                if (sz > 0) m_mode = 1;
            end else if (m_mode == 1) begin
                e = m_q.pop_front();
                m_ctrl = e.ctrl;
                m_rem  = (e.dur == 0) ? 1 : int'(e.dur);
                m_mode = 2;
            end else if (tick) begin
                if (m_rem == 1) begin
                    if (sz > 0) m_mode = 1;
                    else begin m_mode = 0; m_ctrl = 0; end
                end else m_rem--;
            end
            if (cmd_wr && (!full || pop)) m_q.push_back('{cmd_ctrl, cmd_dur});
        end
        h2 = h1; h1 = h0; h0 = bot_updt;
        m_ackp = int_ack;
    endtask

    task automatic compare_all();
        check("bot_ctrl",   32'(bot_ctrl),   32'(m_ctrl));
        check("upd_int",    32'(upd_int),    32'(m_upd));
        check("fifo_cnt",   32'(fifo_cnt),   32'(m_q.size()));
        check("fifo_full",  32'(fifo_full),  32'(m_q.size() == 8));
        check("cmd_ovf",    32'(cmd_ovf),    32'(m_ovf));
        check("miss_cnt",   32'(miss_cnt),   32'(m_miss));
        check("busy",       32'(busy),       32'(m_mode != 0));
        check("wdog_fault", 32'(wdog_fault), 32'd0);
    endtask

    task automatic cycle();
        @(posedge HCLK);
        if (!HRESETn) model_reset(); else model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        #1;
        compare_all();
        cycle();
        HRESETn = 1'b1;
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] d);
        cmd_wr = 1'b1; cmd_ctrl = c; cmd_dur = d;
        cycle();
        cmd_wr = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // One bot update: level high for hi cycles, then low for lo cycles.
    task automatic updt_pulse(input int hi, input int lo);
        bot_updt = 1'b1; run(hi);
        bot_updt = 1'b0; run(lo);
    endtask

    initial begin
        #2;
        do_reset();
        check("rst_bot_ctrl", 32'(bot_ctrl), 32'h00);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);

        // Reset in the middle of a running command.
        push(8'h44, 8'd3); push(8'h55, 8'd3); push(8'h66, 8'd3);
        run(2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_ctrl", 32'(bot_ctrl), 32'h44);
        do_reset();
        check("midrun_rst_ctrl", 32'(bot_ctrl), 32'h00);
        check("midrun_rst_cnt", 32'(fifo_cnt), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);

        // Two-command sequence with a tick every 20 cycles.
        push(8'h33, 8'd2); push(8'h11, 8'd0);
        run(1);
        check("seq_first", 32'(bot_ctrl), 32'h33);
        updt_pulse(10, 10);
        check("seq_first_held", 32'(bot_ctrl), 32'h33);
        updt_pulse(10, 10);
        check("seq_second", 32'(bot_ctrl), 32'h11);
        check("seq_busy", 32'(busy), 32'd1);
        updt_pulse(10, 10);
        check("seq_done_ctrl", 32'(bot_ctrl), 32'h00);
        check("seq_done_busy", 32'(busy), 32'd0);

        // Interrupt: one tick sets, two more count as misses, ack with coincident tick keeps it set.
        do_reset();
        check("int_clear", 32'(upd_int), 32'd0);
        updt_pulse(5, 5);
        check("int_set", 32'(upd_int), 32'd1);
        updt_pulse(5, 5); updt_pulse(5, 5);
        check("int_miss2", 32'(miss_cnt), 32'd2);
        bot_updt = 1'b1; cycle(); cycle();
        int_ack = 1'b1; cycle();
        check("ack_tick_set_wins", 32'(upd_int), 32'd1);
        check("ack_tick_miss", 32'(miss_cnt), 32'd3);
        bot_updt = 1'b0; int_ack = 1'b0; cycle();
        int_ack = 1'b1; cycle();
        check("ack_clears", 32'(upd_int), 32'd0);
        int_ack = 1'b0; cycle();

        // Overflow, then push and pop on the same edge while full.
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(8'h80 + i), 8'd1);
        check("fill_cnt", 32'(fifo_cnt), 32'd8);
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_no_ovf", 32'(cmd_ovf), 32'd0);
        bot_updt = 1'b1; cycle(); cycle(); cycle();
        bot_updt = 1'b0;
        push(8'hA5, 8'd2);
        check("pushpop_cnt", 32'(fifo_cnt), 32'd8);
        check("pushpop_no_ovf", 32'(cmd_ovf), 32'd0);
        check("pushpop_ctrl", 32'(bot_ctrl), 32'h81);
        push(8'hA6, 8'd2);
        check("ovf_set", 32'(cmd_ovf), 32'd1);
        check("ovf_cnt", 32'(fifo_cnt), 32'd8);

        // Flush while running with four queued.
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 8'd3);
        check("preflush_cnt", 32'(fifo_cnt), 32'd4);
        flush = 1'b1; cmd_wr = 1'b1; cmd_ctrl = 8'hEE; cycle();
        flush = 1'b0; cmd_wr = 1'b0;
        check("flush_ctrl", 32'(bot_ctrl), 32'h00);
        check("flush_cnt", 32'(fifo_cnt), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ovf", 32'(cmd_ovf), 32'd0);
        run(3);

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            cmd_wr   = ($urandom_range(0, 2) == 0);
            cmd_ctrl = 8'($urandom);
            cmd_dur  = 8'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) bot_updt = ~bot_updt;
            if ($urandom_range(0, 4) == 0) int_ack = ~int_ack;
            if (i == 2500) begin
                cmd_wr = 1'b0; flush = 1'b0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
